// File: rtl/enemy_step_engine_pkg.sv
// Shared game definitions: cell codes, grid-size defaults and the enemy stepper's FSM encoding.
// Imported by the renderer, the map loader and the enemy step engine.
package enemy_step_engine_pkg;

   localparam int unsigned DEF_GRID_W    = 64;
   localparam int unsigned DEF_GRID_H    = 32;
   localparam int unsigned DEF_X_BITS    = 6;
   localparam int unsigned DEF_Y_BITS    = 5;
   localparam int unsigned DEF_CELL_BITS = 3;
   localparam int unsigned DEF_ATK_BITS  = 4;

   localparam logic [2:0] CELL_EMPTY  = 3'd0;
   localparam logic [2:0] CELL_WALL   = 3'd1;
   localparam logic [2:0] CELL_PLAYER = 3'd2;
   localparam logic [2:0] CELL_ITEM   = 3'd3;
   localparam logic [2:0] CELL_ENEMY  = 3'd4;
   localparam logic [2:0] CELL_MOVED  = 3'd5;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_P1_RD  = 4'd1,
      ST_P1_CHK = 4'd2,
      ST_T1_RD  = 4'd3,
      ST_T1_CHK = 4'd4,
      ST_T2_RD  = 4'd5,
      ST_T2_CHK = 4'd6,
      ST_W_DST  = 4'd7,
      ST_W_SRC  = 4'd8,
      ST_P2_RD  = 4'd9,
      ST_P2_CHK = 4'd10,
      ST_P2_FIX = 4'd11,
      ST_DONE   = 4'd12
   } step_state_e;

endpackage

// File: rtl/enemy_step_engine_grid_scan_counter.sv
// Row-major grid walker: x runs fastest, wraps to 0 and bumps y; flags the final cell.
// Exposes the successor position so the owner can register the next address in advance.
module grid_scan_counter
   import enemy_step_engine_pkg::*;
#(
   parameter int unsigned GRID_W = DEF_GRID_W,
   parameter int unsigned GRID_H = DEF_GRID_H,
   parameter int unsigned X_BITS = DEF_X_BITS,
   parameter int unsigned Y_BITS = DEF_Y_BITS
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic [X_BITS-1:0] nxt_x,
   output logic [Y_BITS-1:0] nxt_y,
   output logic              last
);

   logic [X_BITS-1:0] x_q, x_d;
   logic [Y_BITS-1:0] y_q, y_d;
   logic              x_end_s, y_end_s;

   // Successor position and counter update
   always_comb begin
      x_end_s = (x_q == X_BITS'(GRID_W - 1));
      y_end_s = (y_q == Y_BITS'(GRID_H - 1));
      if (x_end_s) begin
         nxt_x = {X_BITS{1'b0}};
         nxt_y = y_end_s ? {Y_BITS{1'b0}} : (y_q + Y_BITS'(1));
      end else begin
         nxt_x = x_q + X_BITS'(1);
         nxt_y = y_q;
      end
      if (clr) begin
         x_d = {X_BITS{1'b0}};
         y_d = {Y_BITS{1'b0}};
      end else if (inc) begin
         x_d = nxt_x;
         y_d = nxt_y;
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // Position registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= {X_BITS{1'b0}};
         y_q <= {Y_BITS{1'b0}};
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = x_end_s && y_end_s;

endmodule

// File: rtl/enemy_step_engine.sv
// Per-frame enemy updater: pass 1 steps each enemy toward the player (marking it MOVED),
// pass 2 turns MOVED markers back into enemies. Drives the shared grid port only while busy.
module enemy_step_engine
   import enemy_step_engine_pkg::*;
#(
   parameter int unsigned GRID_W    = DEF_GRID_W,
   parameter int unsigned GRID_H    = DEF_GRID_H,
   parameter int unsigned X_BITS    = DEF_X_BITS,
   parameter int unsigned Y_BITS    = DEF_Y_BITS,
   parameter int unsigned CELL_BITS = DEF_CELL_BITS,
   parameter logic [CELL_BITS-1:0] EMPTY_CODE = CELL_BITS'(CELL_EMPTY),
   parameter logic [CELL_BITS-1:0] ENEMY_CODE = CELL_BITS'(CELL_ENEMY),
   parameter logic [CELL_BITS-1:0] MOVED_CODE = CELL_BITS'(CELL_MOVED),
   parameter int unsigned ATK_BITS  = DEF_ATK_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [X_BITS-1:0]    player_x,
   input  logic [Y_BITS-1:0]    player_y,
   output logic                 busy,
   output logic                 done,
   output logic [ATK_BITS-1:0]  attacks,
   output logic [X_BITS-1:0]    grid_x,
   output logic [Y_BITS-1:0]    grid_y,
   input  logic [CELL_BITS-1:0] grid_out,
   output logic                 grid_write,
   output logic [CELL_BITS-1:0] grid_in
);

   localparam int D   = ((X_BITS > Y_BITS) ? int'(X_BITS) : int'(Y_BITS)) + 1;
   localparam int XW1 = X_BITS + 1;
   localparam int YW1 = Y_BITS + 1;
   localparam logic [X_BITS:0] X_LIM = XW1'(GRID_W);
   localparam logic [Y_BITS:0] Y_LIM = YW1'(GRID_H);

   step_state_e state_q, state_d, nxt_p1_s, nxt_p2_s;

   logic [X_BITS-1:0]    px_q, px_d, gx_q, gx_d;
   logic [Y_BITS-1:0]    py_q, py_d, gy_q, gy_d;
   logic [ATK_BITS-1:0]  atk_q, atk_d, attacks_q, attacks_d;
   logic [CELL_BITS-1:0] gin_q, gin_d;
   logic                 busy_q, busy_d, done_q, done_d, wr_q, wr_d;

   logic [X_BITS-1:0] scan_x_s, scan_nx_s;
   logic [Y_BITS-1:0] scan_y_s, scan_ny_s;
   logic              scan_clr_s, scan_inc_s, scan_last_s;

   logic [D-1:0]      diff_x_s, diff_y_s, mag_x_s, mag_y_s;
   logic              dx_zero_s, dy_zero_s, x_primary_s, sec_valid_s, off_grid_s, hits_player_s;
   logic [X_BITS-1:0] step_x_s, prim_x_s, sec_x_s;
   logic [Y_BITS-1:0] step_y_s, prim_y_s, sec_y_s;

   grid_scan_counter #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_scan (
      .clock (clock),
      .rst_n (reset),
      .clr   (scan_clr_s),
      .inc   (scan_inc_s),
      .x     (scan_x_s),
      .y     (scan_y_s),
      .nxt_x (scan_nx_s),
      .nxt_y (scan_ny_s),
      .last  (scan_last_s)
   );

   // Target selection: the MSB of each zero-extended difference is its sign
   always_comb begin
      diff_x_s    = D'(px_q) - D'(scan_x_s);
      diff_y_s    = D'(py_q) - D'(scan_y_s);
      mag_x_s     = diff_x_s[D-1] ? (~diff_x_s + D'(1)) : diff_x_s;
      mag_y_s     = diff_y_s[D-1] ? (~diff_y_s + D'(1)) : diff_y_s;
      dx_zero_s   = (diff_x_s == {D{1'b0}});
      dy_zero_s   = (diff_y_s == {D{1'b0}});
      x_primary_s = (mag_x_s >= mag_y_s);
      step_x_s    = dx_zero_s ? scan_x_s :
                    (diff_x_s[D-1] ? (scan_x_s - X_BITS'(1)) : (scan_x_s + X_BITS'(1)));
      step_y_s    = dy_zero_s ? scan_y_s :
                    (diff_y_s[D-1] ? (scan_y_s - Y_BITS'(1)) : (scan_y_s + Y_BITS'(1)));
      prim_x_s    = x_primary_s ? step_x_s : scan_x_s;
      prim_y_s    = x_primary_s ? scan_y_s : step_y_s;
      sec_x_s     = x_primary_s ? scan_x_s : step_x_s;
      sec_y_s     = x_primary_s ? step_y_s : scan_y_s;
      sec_valid_s = x_primary_s ? !dy_zero_s : !dx_zero_s;
      // An enemy already on the player also lands here: its primary step is a no-op
      hits_player_s = (prim_x_s == px_q) && (prim_y_s == py_q);
      off_grid_s    = ({1'b0, px_q} >= X_LIM) || ({1'b0, py_q} >= Y_LIM);
   end

   // Next-state logic plus player latch, attack counter and scan control
   always_comb begin
      state_d    = state_q;
      px_d       = px_q;
      py_d       = py_q;
      atk_d      = atk_q;
      scan_clr_s = 1'b0;
      scan_inc_s = 1'b0;
      nxt_p1_s   = scan_last_s ? ST_P2_RD : ST_P1_RD;
      nxt_p2_s   = scan_last_s ? ST_DONE : ST_P2_RD;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_P1_RD;
               px_d       = player_x;
               py_d       = player_y;
               atk_d      = {ATK_BITS{1'b0}};
               scan_clr_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_P1_RD: state_d = ST_P1_CHK;
         ST_P1_CHK: begin
            if ((grid_out == ENEMY_CODE) && !off_grid_s && !hits_player_s) begin
               state_d = ST_T1_RD;
            end else begin
               if ((grid_out == ENEMY_CODE) && !off_grid_s &&
                   (atk_q != {ATK_BITS{1'b1}})) begin
                  atk_d = atk_q + ATK_BITS'(1);
               end else begin
                  atk_d = atk_q;
               end
               scan_inc_s = 1'b1;
               state_d    = nxt_p1_s;
            end
         end
         ST_T1_RD: state_d = ST_T1_CHK;
         ST_T1_CHK: begin
            if (grid_out == EMPTY_CODE) begin
               state_d = ST_W_DST;
            end else if (sec_valid_s) begin
               state_d = ST_T2_RD;
            end else begin
               scan_inc_s = 1'b1;
               state_d    = nxt_p1_s;
            end
         end
         ST_T2_RD: state_d = ST_T2_CHK;
         ST_T2_CHK: begin
            if (grid_out == EMPTY_CODE) begin
               state_d = ST_W_DST;
            end else begin
               scan_inc_s = 1'b1;
               state_d    = nxt_p1_s;
            end
         end
         ST_W_DST: state_d = ST_W_SRC;
         ST_W_SRC: begin
            scan_inc_s = 1'b1;
            state_d    = nxt_p1_s;
         end
         ST_P2_RD: state_d = ST_P2_CHK;
         ST_P2_CHK: begin
            if (grid_out == MOVED_CODE) begin
               state_d = ST_P2_FIX;
            end else begin
               scan_inc_s = 1'b1;
               state_d    = nxt_p2_s;
            end
         end
         ST_P2_FIX: begin
            scan_inc_s = 1'b1;
            state_d    = nxt_p2_s;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every port pin comes straight from a flop
   always_comb begin
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      wr_d      = 1'b0;
      gx_d      = gx_q;
      gy_d      = gy_q;
      gin_d     = gin_q;
      attacks_d = attacks_q;
      case (state_d)
         ST_P1_RD, ST_P2_RD: begin
            if (scan_clr_s) begin
               gx_d = {X_BITS{1'b0}};
               gy_d = {Y_BITS{1'b0}};
            end else begin
               gx_d = scan_nx_s;
               gy_d = scan_ny_s;
            end
         end
         ST_T1_RD: begin
            gx_d = prim_x_s;
            gy_d = prim_y_s;
         end
         ST_T2_RD: begin
            gx_d = sec_x_s;
            gy_d = sec_y_s;
         end
         ST_W_DST: begin
            if (state_q == ST_T1_CHK) begin
               gx_d = prim_x_s;
               gy_d = prim_y_s;
            end else begin
               gx_d = sec_x_s;
               gy_d = sec_y_s;
            end
            gin_d = MOVED_CODE;
            wr_d  = 1'b1;
         end
         ST_W_SRC: begin
            gx_d  = scan_x_s;
            gy_d  = scan_y_s;
            gin_d = EMPTY_CODE;
            wr_d  = 1'b1;
         end
         ST_P2_FIX: begin
            gx_d  = scan_x_s;
            gy_d  = scan_y_s;
            gin_d = ENEMY_CODE;
            wr_d  = 1'b1;
         end
         ST_DONE: attacks_d = atk_q;
         default: wr_d = 1'b0;
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         px_q      <= {X_BITS{1'b0}};
         py_q      <= {Y_BITS{1'b0}};
         atk_q     <= {ATK_BITS{1'b0}};
         attacks_q <= {ATK_BITS{1'b0}};
         gx_q      <= {X_BITS{1'b0}};
         gy_q      <= {Y_BITS{1'b0}};
         gin_q     <= {CELL_BITS{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         px_q      <= px_d;
         py_q      <= py_d;
         atk_q     <= atk_d;
         attacks_q <= attacks_d;
         gx_q      <= gx_d;
         gy_q      <= gy_d;
         gin_q     <= gin_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign attacks    = attacks_q;
   assign grid_x     = gx_q;
   assign grid_y     = gy_q;
   assign grid_in    = gin_q;
   assign grid_write = wr_q;

endmodule
